// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: byte width, scheduler
// defaults and the scheduler FSM encoding.
package uart_pkg;

   localparam int BYTE_W               = 8;
   localparam int BUSY_TIMEOUT_DEFAULT = 16;

   typedef logic [2:0] sched_state_t;

   localparam sched_state_t ST_IDLE      = 3'd0;
   localparam sched_state_t ST_LAUNCH    = 3'd1;
   localparam sched_state_t ST_WAIT_BUSY = 3'd2;
   localparam sched_state_t ST_WAIT_DONE = 3'd3;
   localparam sched_state_t ST_DONE      = 3'd4;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by rr_ptr, pick the
// lowest set bit, rotate the one-hot result back.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N-1:0]     grant
);

   logic [N-1:0] w_req_rot;
   logic [N-1:0] w_gnt_rot;

   always_comb begin
      w_req_rot = '0;
      for (int i = 0; i < N; i++) begin
         w_req_rot[i] = req[(i + int'(rr_ptr)) % N];
      end
   end

   // Two's complement isolates the lowest set bit, i.e. the first requester at or after rr_ptr.
   assign w_gnt_rot = w_req_rot & (~w_req_rot + {{(N-1){1'b0}}, 1'b1});

   always_comb begin
      grant = '0;
      for (int j = 0; j < N; j++) begin
         grant[j] = w_gnt_rot[(j + N - int'(rr_ptr)) % N];
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx among N_REQ byte-stream requesters, locking the
// transmitter to a requester for a whole message (until a last byte).
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int N_REQ        = 3,
   parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [BYTE_W*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        ack,
   output logic [N_REQ-1:0]        grant,
   output logic                    tx_start,
   output logic [BYTE_W-1:0]       tx_data,
   input  logic                    tx_idle_ready,
   output logic                    busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BUSY_TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

   sched_state_t      r_state;
   logic              r_locked;
   logic [N_REQ-1:0]  r_grant;
   logic [IDX_W-1:0]  r_owner;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [BYTE_W-1:0] r_tx_data;
   logic              r_last_q;
   logic [CNT_W-1:0]  r_cnt;

   logic [N_REQ-1:0]  w_arb_grant;
   logic [IDX_W-1:0]  w_arb_idx;
   logic [IDX_W-1:0]  w_sel_idx;
   logic              w_owner_req;
   logic [BYTE_W-1:0] w_sel_data;
   logic              w_sel_last;
   logic              w_launch;
   logic [CNT_W-1:0]  w_cnt_inc;

   rr_arbiter #(
      .N     (N_REQ),
      .PTR_W (IDX_W)
   ) u_rr_arbiter (
      .req    (req),
      .rr_ptr (r_rr_ptr),
      .grant  (w_arb_grant)
   );

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_arb_idx   = '0;
      w_owner_req = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_arb_grant[i])       w_arb_idx   = IDX_W'(i);
         if (r_owner == IDX_W'(i)) w_owner_req = req[i];
      end
   end

   assign w_sel_idx = r_locked ? r_owner : w_arb_idx;

   always_comb begin
      w_sel_data = '0;
      w_sel_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_sel_idx == IDX_W'(i)) begin
            w_sel_data = req_data[i*BYTE_W +: BYTE_W];
            w_sel_last = req_last[i];
         end
      end
   end

   // A byte only launches into an idle transmitter; otherwise the request waits in IDLE.
   assign w_launch  = tx_idle_ready && (r_locked ? w_owner_req : (|req));
   assign w_cnt_inc = (r_cnt == CNT_LIMIT) ? r_cnt : r_cnt + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_locked  <= 1'b0;
         r_grant   <= '0;
         r_owner   <= '0;
         r_rr_ptr  <= '0;
         r_tx_data <= '0;
         r_last_q  <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_locked && !w_owner_req) begin
                  r_locked <= 1'b0;
                  r_grant  <= '0;
               end else if (w_launch) begin
                  r_state   <= ST_LAUNCH;
                  r_locked  <= 1'b1;
                  r_owner   <= w_sel_idx;
                  r_tx_data <= w_sel_data;
                  r_last_q  <= w_sel_last;
                  r_cnt     <= '0;
                  if (!r_locked) r_grant <= w_arb_grant;
               end
            end
            ST_LAUNCH: begin
               r_cnt   <= w_cnt_inc;
               r_state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               r_cnt <= w_cnt_inc;
               if (!tx_idle_ready)              r_state <= ST_WAIT_DONE;
               else if (w_cnt_inc == CNT_LIMIT) r_state <= ST_DONE;
            end
            ST_WAIT_DONE: begin
               if (tx_idle_ready) r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (r_last_q) begin
                  r_locked <= 1'b0;
                  r_grant  <= '0;
                  r_rr_ptr <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_start = (r_state == ST_LAUNCH);
   assign ack      = tx_start ? r_grant : '0;
   assign grant    = r_grant;
   assign tx_data  = r_tx_data;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a stub uart_tx, queued requesters
// and one task per scenario with hand-computed expectations.
module tb_uart_tx_scheduler;

   localparam int N         = 3;
   localparam int TIMEOUT   = 16;
   localparam int STUB_BUSY = 3;
   localparam int QD        = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   ack;
   logic [N-1:0]   grant;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           tx_idle_ready;
   logic           busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [8:0] rq_mem [N][QD];
   int         rq_head [N];
   int         rq_len  [N];
   bit         stub_stuck;
   int         stub_cnt;

   logic [7:0]   log_data  [$];
   logic [N-1:0] log_grant [$];
   logic [N-1:0] log_ack   [$];
   int           log_cyc   [$];

   uart_tx_scheduler #(
      .N_REQ        (N),
      .BUSY_TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_data      (req_data),
      .req_last      (req_last),
      .ack           (ack),
      .grant         (grant),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .tx_idle_ready (tx_idle_ready),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // One cycle: observe at the falling edge, then update the stub transmitter and requesters.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (tx_start) begin
         log_data.push_back(tx_data);
         log_grant.push_back(grant);
         log_ack.push_back(ack);
         log_cyc.push_back(cyc);
      end
      if (rst) begin
         stub_cnt      = 0;
         tx_idle_ready = 1'b1;
      end else if (tx_start && !stub_stuck) begin
         stub_cnt      = STUB_BUSY;
         tx_idle_ready = 1'b0;
      end else if (stub_cnt > 0) begin
         stub_cnt--;
         if (stub_cnt == 0) tx_idle_ready = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         if (!rst && ack[i] && rq_head[i] < rq_len[i]) rq_head[i]++;
         if (!rst && rq_head[i] < rq_len[i]) begin
            req[i]            = 1'b1;
            req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
            req_last[i]       = rq_mem[i][rq_head[i]][8];
         end else begin
            req[i]            = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]       = 1'b0;
         end
      end
   endtask

   task automatic clear_queues();
      for (int i = 0; i < N; i++) begin
         rq_head[i] = 0;
         rq_len[i]  = 0;
      end
   endtask

   task automatic clear_logs();
      log_data.delete();
      log_grant.delete();
      log_ack.delete();
      log_cyc.delete();
   endtask

   task automatic load(input int r, input logic [7:0] d, input logic l);
      rq_mem[r][rq_len[r]] = {l, d};
      rq_len[r]++;
   endtask

   function automatic bit queues_empty();
      bit e = 1'b1;
      for (int i = 0; i < N; i++) if (rq_head[i] < rq_len[i]) e = 1'b0;
      return e;
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      clear_queues();
      repeat (3) step();
      rst = 1'b0;
      step();
      clear_logs();
   endtask

   task automatic wait_drain(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         step();
         if (queues_empty() && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_starts(input int n, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         if (log_data.size() >= n) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL reset_ack: got %b want 000", ack); end
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", grant); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
   endtask

   task automatic test_single();
      bit ok;
      int p;
      apply_reset();
      load(0, 8'h41, 1'b1);
      step();
      p = cyc;
      wait_drain(100, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_drain: got timeout want idle within 100 cycles"); end
      n_cmp++; if (log_data.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d starts want 1", log_data.size()); end
      if (log_data.size() >= 1) begin
         n_cmp++; if (log_data[0] !== 8'h41) begin n_bad++; $display("FAIL single_data: got %h want 41", log_data[0]); end
         n_cmp++; if (log_ack[0] !== 3'b001) begin n_bad++; $display("FAIL single_ack: got %b want 001", log_ack[0]); end
         n_cmp++; if (log_grant[0] !== 3'b001) begin n_bad++; $display("FAIL single_grant: got %b want 001", log_grant[0]); end
         n_cmp++; if (log_cyc[0] != p + 1) begin n_bad++; $display("FAIL single_latency: got %0d want 1 cycle", log_cyc[0] - p); end
      end
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL single_grant_after: got %b want 000", grant); end
      repeat (5) step();
      n_cmp++; if (log_data.size() != 1) begin n_bad++; $display("FAIL single_no_extra: got %0d starts want 1", log_data.size()); end
   endtask

   task automatic test_two_msgs();
      bit ok;
      logic [7:0]   exp_d [4];
      logic [N-1:0] exp_g [4];
      exp_d = '{8'h77, 8'h73, 8'h42, 8'h43};
      exp_g = '{3'b001, 3'b001, 3'b100, 3'b100};
      apply_reset();
      load(0, 8'h77, 1'b0); load(0, 8'h73, 1'b1);
      load(2, 8'h42, 1'b0); load(2, 8'h43, 1'b1);
      wait_drain(200, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL two_msgs_drain: got timeout want idle within 200 cycles"); end
      n_cmp++; if (log_data.size() != 4) begin n_bad++; $display("FAIL two_msgs_count: got %0d starts want 4", log_data.size()); end
      for (int i = 0; i < 4 && i < log_data.size(); i++) begin
         n_cmp++;
         if (log_data[i] !== exp_d[i] || log_grant[i] !== exp_g[i] || log_ack[i] !== exp_g[i]) begin
            n_bad++;
            $display("FAIL two_msgs[%0d]: got data %h grant %b ack %b want data %h grant %b ack %b",
                     i, log_data[i], log_grant[i], log_ack[i], exp_d[i], exp_g[i], exp_g[i]);
         end
      end
   endtask

   task automatic test_fairness();
      bit ok;
      logic [7:0]   exp_d [6];
      logic [N-1:0] exp_g [6];
      exp_d = '{8'h30, 8'h50, 8'h60, 8'h31, 8'h51, 8'h61};
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      apply_reset();
      load(0, 8'h30, 1'b1); load(0, 8'h31, 1'b1);
      load(1, 8'h50, 1'b1); load(1, 8'h51, 1'b1);
      load(2, 8'h60, 1'b1); load(2, 8'h61, 1'b1);
      wait_drain(300, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL fair_drain: got timeout want idle within 300 cycles"); end
      n_cmp++; if (log_data.size() != 6) begin n_bad++; $display("FAIL fair_count: got %0d starts want 6", log_data.size()); end
      for (int i = 0; i < 6 && i < log_data.size(); i++) begin
         n_cmp++;
         if (log_data[i] !== exp_d[i] || log_grant[i] !== exp_g[i]) begin
            n_bad++;
            $display("FAIL fair[%0d]: got data %h grant %b want data %h grant %b",
                     i, log_data[i], log_grant[i], exp_d[i], exp_g[i]);
         end
      end
   endtask

   // Stuck transmitter: DONE lands TIMEOUT cycles after tx_start, IDLE (busy=0) one later, next LAUNCH one after that.
   task automatic test_timeout();
      bit ok;
      int l0;
      int k;
      apply_reset();
      stub_stuck = 1'b1;
      load(0, 8'h10, 1'b1); load(0, 8'h11, 1'b1);
      wait_starts(1, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_first_start: got timeout want tx_start within 50 cycles"); end
      l0 = cyc;
      k  = 0;
      while (busy && k < 100) begin
         step();
         k++;
      end
      n_cmp++; if (cyc - l0 != TIMEOUT + 1) begin n_bad++; $display("FAIL tmo_busy_low: got %0d cycles want %0d", cyc - l0, TIMEOUT + 1); end
      wait_starts(2, 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_second_start: got timeout want tx_start within 50 cycles"); end
      if (ok) begin
         n_cmp++; if (log_cyc[1] - log_cyc[0] != TIMEOUT + 2) begin n_bad++; $display("FAIL tmo_spacing: got %0d want %0d", log_cyc[1] - log_cyc[0], TIMEOUT + 2); end
         n_cmp++; if (log_data[1] !== 8'h11 || log_grant[1] !== 3'b001) begin n_bad++; $display("FAIL tmo_second_byte: got %h/%b want 11/001", log_data[1], log_grant[1]); end
      end
      wait_drain(100, ok);
      stub_stuck = 1'b0;
   endtask

   task automatic test_withdraw();
      bit ok;
      bit saw_unlock;
      int k;
      apply_reset();
      load(0, 8'h11, 1'b0);
      load(1, 8'h44, 1'b1);
      wait_starts(1, 50, ok);
      saw_unlock = 1'b0;
      k = 0;
      while (log_data.size() < 2 && k < 100) begin
         step();
         k++;
         if (log_data.size() < 2 && grant === 3'b000 && !busy) saw_unlock = 1'b1;
      end
      n_cmp++; if (log_data.size() != 2) begin n_bad++; $display("FAIL withdraw_count: got %0d starts want 2", log_data.size()); end
      n_cmp++; if (!saw_unlock) begin n_bad++; $display("FAIL withdraw_unlock: got lock held want grant 000 in IDLE"); end
      if (log_data.size() >= 2) begin
         n_cmp++; if (log_data[0] !== 8'h11 || log_grant[0] !== 3'b001) begin n_bad++; $display("FAIL withdraw_first: got %h/%b want 11/001", log_data[0], log_grant[0]); end
         n_cmp++; if (log_data[1] !== 8'h44 || log_grant[1] !== 3'b010) begin n_bad++; $display("FAIL withdraw_next: got %h/%b want 44/010", log_data[1], log_grant[1]); end
      end
      wait_drain(100, ok);
      n_cmp++; if (!ok || grant !== 3'b000) begin n_bad++; $display("FAIL withdraw_end: got ok=%b grant %b want ok=1 grant 000", ok, grant); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [7:0]   exp_d [3];
      logic [N-1:0] exp_g [3];
      exp_d = '{8'h70, 8'h71, 8'h72};
      exp_g = '{3'b001, 3'b010, 3'b100};
      apply_reset();
      load(0, 8'h20, 1'b1);
      wait_drain(100, ok);
      clear_logs();
      load(2, 8'hAA, 1'b0); load(2, 8'hAB, 1'b1);
      wait_starts(1, 50, ok);
      n_cmp++; if (!ok || log_grant[0] !== 3'b100) begin n_bad++; $display("FAIL rstmid_owner: got ok=%b grant %b want ok=1 grant 100", ok, grant); end
      repeat (2) step();
      n_cmp++; if (busy !== 1'b1 || tx_idle_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_wait_done: got busy %b idle_ready %b want 1 0", busy, tx_idle_ready); end
      rst = 1'b1;
      clear_queues();
      clear_logs();
      step();
      n_cmp++; if (tx_start !== 1'b0 || ack !== 3'b000) begin n_bad++; $display("FAIL rstmid_start_ack: got %b %b want 0 000", tx_start, ack); end
      n_cmp++; if (grant !== 3'b000 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_grant_busy: got %b %b want 000 0", grant, busy); end
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
      step();
      rst = 1'b0;
      load(0, 8'h70, 1'b1); load(1, 8'h71, 1'b1); load(2, 8'h72, 1'b1);
      wait_drain(200, ok);
      n_cmp++; if (!ok || log_data.size() != 3) begin n_bad++; $display("FAIL rstmid_after: got ok=%b starts %0d want ok=1 starts 3", ok, log_data.size()); end
      for (int i = 0; i < 3 && i < log_data.size(); i++) begin
         n_cmp++;
         if (log_data[i] !== exp_d[i] || log_grant[i] !== exp_g[i]) begin
            n_bad++;
            $display("FAIL rstmid[%0d]: got data %h grant %b want data %h grant %b",
                     i, log_data[i], log_grant[i], exp_d[i], exp_g[i]);
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      req           = '0;
      req_data      = '0;
      req_last      = '0;
      tx_idle_ready = 1'b1;
      stub_cnt      = 0;
      stub_stuck    = 1'b0;
      clear_queues();
      test_reset();
      test_single();
      test_two_msgs();
      test_fairness();
      test_timeout();
      test_withdraw();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
